// File: rtl/gpio_isol_sequencer.sv
// gpio_isol_sequencer: releases active-low pad isolation group by group after configuration, re-isolates all pads at once on request
// Ports:
//    CK          clock
//    RSTN        asynchronous active-low reset
//    CONFIG_DONE configuration complete (level)
//    ISOL_REQ    level request to isolate every pad
//    IO_ISOL_N   per-pad isolation, 0 = isolated, 1 = released
//    READY       every group released
//    BUSY        release sequence in progress
//    GROUP_IDX   index of the most recently released group
// Option: define GPIO_ISOL_SEQ_CDC_SYNC_EN to pass CONFIG_DONE through a 2-flop synchronizer;
//    otherwise CONFIG_DONE must be synchronous to CK and a single register is used.
module gpio_isol_sequencer #(
   parameter  int NUM_IO        = 16,
   parameter  int GROUP_SIZE    = 4,
   parameter  int SETTLE_CYCLES = 8,
   parameter  int CNT_W         = 8,
   localparam int NUM_GROUPS    = (NUM_IO + GROUP_SIZE - 1) / GROUP_SIZE,
   localparam int GW            = $clog2(NUM_GROUPS + 1)
) (
   input  logic              CK,
   input  logic              RSTN,
   input  logic              CONFIG_DONE,
   input  logic              ISOL_REQ,
   output logic [NUM_IO-1:0] IO_ISOL_N,
   output logic              READY,
   output logic              BUSY,
   output logic [GW-1:0]     GROUP_IDX
);

   typedef enum logic [1:0] {ISOLATED, SETTLE, ACTIVE} state_t;

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES);
   localparam logic [GW-1:0]    LAST   = GW'(NUM_GROUPS - 1);

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              cfg_ok;
   logic [GW-1:0]     nxt_idx;
   logic [NUM_IO-1:0] nxt_mask;

`ifdef GPIO_ISOL_SEQ_CDC_SYNC_EN
   logic [1:0] sync_q;
   always_ff @(posedge CK or negedge RSTN)
      if (!RSTN) sync_q <= '0;
      else       sync_q <= {sync_q[0], CONFIG_DONE};
   assign cfg_ok = sync_q[1];
`else
   logic cfg_q;
   always_ff @(posedge CK or negedge RSTN)
      if (!RSTN) cfg_q <= 1'b0;
      else       cfg_q <= CONFIG_DONE;
   assign cfg_ok = cfg_q;
`endif

   // group released on the next step: group 0 when leaving ISOLATED, else the one after GROUP_IDX
   assign nxt_idx = (state_q == ISOLATED) ? '0 : GROUP_IDX + GW'(1);

   // pads of nxt_idx; the last group is naturally clipped at NUM_IO
   always_comb begin
      nxt_mask = '0;
      for (int i = 0; i < NUM_IO; i++)
         nxt_mask[i] = (i / GROUP_SIZE) == int'(nxt_idx);
   end

   always_ff @(posedge CK or negedge RSTN) begin
      if (!RSTN) begin
         state_q   <= ISOLATED;
         cnt_q     <= '0;
         IO_ISOL_N <= '0;
         READY     <= 1'b0;
         BUSY      <= 1'b0;
         GROUP_IDX <= '0;
      end else if (state_q != ISOLATED && (ISOL_REQ || !cfg_ok)) begin
         // abort wins over any release due on this edge: all pads isolate in one step
         state_q   <= ISOLATED;
         cnt_q     <= '0;
         IO_ISOL_N <= '0;
         READY     <= 1'b0;
         BUSY      <= 1'b0;
         GROUP_IDX <= '0;
      end else begin
         case (state_q)
            ISOLATED:
               if (cfg_ok && !ISOL_REQ) begin
                  state_q   <= SETTLE;
                  cnt_q     <= RELOAD;
                  IO_ISOL_N <= nxt_mask;
                  BUSY      <= 1'b1;
                  GROUP_IDX <= '0;
               end
            SETTLE:
               if (cnt_q == CNT_W'(1)) begin
                  if (GROUP_IDX < LAST) begin
                     cnt_q     <= RELOAD;
                     IO_ISOL_N <= IO_ISOL_N | nxt_mask;
                     GROUP_IDX <= nxt_idx;
                  end else begin
                     state_q <= ACTIVE;
                     cnt_q   <= '0;
                     READY   <= 1'b1;
                     BUSY    <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_isol_sequencer.sv
// tb_gpio_isol_sequencer: directed self-checking bench for gpio_isol_sequencer (16/4/8 and 10/4/8 instances)
module tb_gpio_isol_sequencer;

`ifdef GPIO_ISOL_SEQ_CDC_SYNC_EN
   localparam int T0 = 3;
`else
   localparam int T0 = 2;
`endif

   logic        CK = 1'b0;
   logic        RSTN = 1'b0;
   logic        CONFIG_DONE = 1'b0;
   logic        ISOL_REQ = 1'b0;
   logic [15:0] IO_ISOL_N;
   logic        READY, BUSY;
   logic [2:0]  GROUP_IDX;
   logic [9:0]  IO10;
   logic        READY10, BUSY10;
   logic [1:0]  IDX10;

   int n_checks = 0;
   int n_fail = 0;

   always #5 CK = ~CK;

   gpio_isol_sequencer dut (
      .CK(CK), .RSTN(RSTN), .CONFIG_DONE(CONFIG_DONE), .ISOL_REQ(ISOL_REQ),
      .IO_ISOL_N(IO_ISOL_N), .READY(READY), .BUSY(BUSY), .GROUP_IDX(GROUP_IDX)
   );

   gpio_isol_sequencer #(.NUM_IO(10), .GROUP_SIZE(4), .SETTLE_CYCLES(8), .CNT_W(8)) dut10 (
      .CK(CK), .RSTN(RSTN), .CONFIG_DONE(CONFIG_DONE), .ISOL_REQ(ISOL_REQ),
      .IO_ISOL_N(IO10), .READY(READY10), .BUSY(BUSY10), .GROUP_IDX(IDX10)
   );

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic do_reset();
      RSTN = 1'b0;
      CONFIG_DONE = 1'b0;
      ISOL_REQ = 1'b0;
      tick();
      tick();
      RSTN = 1'b1;
   endtask

   task automatic test_reset();
      RSTN = 1'b0;
      CONFIG_DONE = 1'b0;
      ISOL_REQ = 1'b0;
      tick();
      n_checks++;
      if (IO_ISOL_N !== 16'h0 || READY !== 1'b0 || BUSY !== 1'b0 || GROUP_IDX !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_in: io=%h ready=%b busy=%b idx=%0d expected 0000/0/0/0", IO_ISOL_N, READY, BUSY, GROUP_IDX);
      end
      n_checks++;
      if (IO10 !== 10'h0 || READY10 !== 1'b0 || BUSY10 !== 1'b0 || IDX10 !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_in10: io=%h ready=%b busy=%b idx=%0d expected 000/0/0/0", IO10, READY10, BUSY10, IDX10);
      end
      RSTN = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         n_checks++;
         if (IO_ISOL_N !== 16'h0 || READY !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle cycle %0d: io=%h ready=%b busy=%b expected 0000/0/0", c, IO_ISOL_N, READY, BUSY);
         end
      end
   endtask

   task automatic test_release();
      int k;
      logic [15:0] exp_io;
      logic [2:0] exp_idx;
      logic exp_ready, exp_busy;
      do_reset();
      CONFIG_DONE = 1'b1;
      for (int e = 1; e <= T0 + 34; e++) begin
         tick();
         k = (e < T0) ? -1 : (((e - T0) / 8 > 3) ? 3 : (e - T0) / 8);
         exp_io = (k < 0) ? 16'h0 : 16'((32'h1 << (4 * (k + 1))) - 1);
         exp_idx = (k < 0) ? 3'd0 : 3'(k);
         exp_ready = (e >= T0 + 32);
         exp_busy = (e >= T0) && (e < T0 + 32);
         n_checks++;
         if (IO_ISOL_N !== exp_io) begin
            n_fail++;
            $display("FAIL release_io edge %0d: got %h expected %h", e, IO_ISOL_N, exp_io);
         end
         n_checks++;
         if (READY !== exp_ready) begin
            n_fail++;
            $display("FAIL release_ready edge %0d: got %b expected %b", e, READY, exp_ready);
         end
         n_checks++;
         if (BUSY !== exp_busy) begin
            n_fail++;
            $display("FAIL release_busy edge %0d: got %b expected %b", e, BUSY, exp_busy);
         end
         n_checks++;
         if (GROUP_IDX !== exp_idx) begin
            n_fail++;
            $display("FAIL release_idx edge %0d: got %0d expected %0d", e, GROUP_IDX, exp_idx);
         end
      end
   endtask

   task automatic test_isol_req();
      do_reset();
      CONFIG_DONE = 1'b1;
      repeat (T0 + 11) tick();
      n_checks++;
      if (IO_ISOL_N !== 16'h00FF || BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL isol_pre: io=%h busy=%b expected 00ff/1", IO_ISOL_N, BUSY);
      end
      ISOL_REQ = 1'b1;
      tick();
      n_checks++;
      if (IO_ISOL_N !== 16'h0 || BUSY !== 1'b0 || READY !== 1'b0 || GROUP_IDX !== 3'd0) begin
         n_fail++;
         $display("FAIL isol_abort: io=%h busy=%b ready=%b idx=%0d expected 0000/0/0/0", IO_ISOL_N, BUSY, READY, GROUP_IDX);
      end
      ISOL_REQ = 1'b0;
      tick();
      n_checks++;
      if (IO_ISOL_N !== 16'h000F || BUSY !== 1'b1 || GROUP_IDX !== 3'd0) begin
         n_fail++;
         $display("FAIL isol_rerelease: io=%h busy=%b idx=%0d expected 000f/1/0", IO_ISOL_N, BUSY, GROUP_IDX);
      end
      repeat (7) tick();
      n_checks++;
      if (IO_ISOL_N !== 16'h000F) begin
         n_fail++;
         $display("FAIL isol_g1_early: io=%h expected 000f", IO_ISOL_N);
      end
      tick();
      n_checks++;
      if (IO_ISOL_N !== 16'h00FF || GROUP_IDX !== 3'd1) begin
         n_fail++;
         $display("FAIL isol_g1: io=%h idx=%0d expected 00ff/1", IO_ISOL_N, GROUP_IDX);
      end
      ISOL_REQ = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         n_checks++;
         if (IO_ISOL_N !== 16'h0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL isol_hold cycle %0d: io=%h busy=%b expected 0000/0", c, IO_ISOL_N, BUSY);
         end
      end
      ISOL_REQ = 1'b0;
      tick();
      n_checks++;
      if (IO_ISOL_N !== 16'h000F || BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL isol_hold_release: io=%h busy=%b expected 000f/1", IO_ISOL_N, BUSY);
      end
   endtask

   task automatic test_config_drop();
      do_reset();
      CONFIG_DONE = 1'b1;
      repeat (T0 + 32) tick();
      n_checks++;
      if (IO_ISOL_N !== 16'hFFFF || READY !== 1'b1 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_active: io=%h ready=%b busy=%b expected ffff/1/0", IO_ISOL_N, READY, BUSY);
      end
      CONFIG_DONE = 1'b0;
      for (int j = 1; j <= T0; j++) begin
         tick();
         n_checks++;
         if (j < T0 && (IO_ISOL_N !== 16'hFFFF || READY !== 1'b1)) begin
            n_fail++;
            $display("FAIL drop_latency edge %0d: io=%h ready=%b expected ffff/1", j, IO_ISOL_N, READY);
         end else if (j == T0 && (IO_ISOL_N !== 16'h0 || READY !== 1'b0 || GROUP_IDX !== 3'd0)) begin
            n_fail++;
            $display("FAIL drop_abort edge %0d: io=%h ready=%b idx=%0d expected 0000/0/0", j, IO_ISOL_N, READY, GROUP_IDX);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      CONFIG_DONE = 1'b1;
      repeat (T0 + 17) tick();
      n_checks++;
      if (IO_ISOL_N !== 16'h0FFF || BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL arst_pre: io=%h busy=%b expected 0fff/1", IO_ISOL_N, BUSY);
      end
      #2;
      RSTN = 1'b0;
      #1;
      n_checks++;
      if (IO_ISOL_N !== 16'h0 || READY !== 1'b0 || BUSY !== 1'b0 || GROUP_IDX !== 3'd0) begin
         n_fail++;
         $display("FAIL arst_immediate: io=%h ready=%b busy=%b idx=%0d expected 0000/0/0/0", IO_ISOL_N, READY, BUSY, GROUP_IDX);
      end
      tick();
      RSTN = 1'b1;
      for (int j = 1; j <= T0; j++) begin
         tick();
         n_checks++;
         if (j < T0 && IO_ISOL_N !== 16'h0) begin
            n_fail++;
            $display("FAIL arst_wait edge %0d: io=%h expected 0000", j, IO_ISOL_N);
         end else if (j == T0 && (IO_ISOL_N !== 16'h000F || BUSY !== 1'b1)) begin
            n_fail++;
            $display("FAIL arst_restart edge %0d: io=%h busy=%b expected 000f/1", j, IO_ISOL_N, BUSY);
         end
      end
   endtask

   task automatic test_partial_group();
      do_reset();
      CONFIG_DONE = 1'b1;
      for (int e = 1; e <= T0 + 25; e++) begin
         tick();
         if (e == T0 - 1 || e == T0 || e == T0 + 7 || e == T0 + 8 || e == T0 + 16 || e == T0 + 23 || e == T0 + 24) begin
            n_checks++;
            if (e == T0 - 1 && IO10 !== 10'h000) begin
               n_fail++;
               $display("FAIL part_pre edge %0d: io=%h expected 000", e, IO10);
            end
            if (e == T0 && IO10 !== 10'h00F) begin
               n_fail++;
               $display("FAIL part_g0 edge %0d: io=%h expected 00f", e, IO10);
            end
            if (e == T0 + 7 && IO10 !== 10'h00F) begin
               n_fail++;
               $display("FAIL part_g1_early edge %0d: io=%h expected 00f", e, IO10);
            end
            if (e == T0 + 8 && IO10 !== 10'h0FF) begin
               n_fail++;
               $display("FAIL part_g1 edge %0d: io=%h expected 0ff", e, IO10);
            end
            if (e == T0 + 16 && (IO10 !== 10'h3FF || IDX10 !== 2'd2)) begin
               n_fail++;
               $display("FAIL part_g2 edge %0d: io=%h idx=%0d expected 3ff/2", e, IO10, IDX10);
            end
            if (e == T0 + 23 && (READY10 !== 1'b0 || BUSY10 !== 1'b1)) begin
               n_fail++;
               $display("FAIL part_ready_early edge %0d: ready=%b busy=%b expected 0/1", e, READY10, BUSY10);
            end
            if (e == T0 + 24 && (READY10 !== 1'b1 || BUSY10 !== 1'b0 || IO10 !== 10'h3FF)) begin
               n_fail++;
               $display("FAIL part_ready edge %0d: ready=%b busy=%b io=%h expected 1/0/3ff", e, READY10, BUSY10, IO10);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_release();
      test_isol_req();
      test_config_drop();
      test_async_reset();
      test_partial_group();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
